// File: rtl/filter_pkg.sv
// Shared parameters and types for the filter-channel output path.
package filter_pkg;

   localparam int unsigned N_CH_DEF = 4;
   localparam int unsigned W_DEF    = 32;
   localparam int unsigned CH_W_DEF = $clog2(N_CH_DEF);

   typedef logic [CH_W_DEF-1:0] ch_id_t;

   localparam logic [W_DEF-1:0] MOST_NEG = {1'b1, {(W_DEF-1){1'b0}}};

endpackage

// File: rtl/sign_mag_unit.sv
// Combinational two's-complement to sign/magnitude conversion with optional
// clamping of the most-negative input.
module sign_mag_unit
   import filter_pkg::*;
#(
   parameter int unsigned W   = W_DEF,
   parameter bit          SAT = 1'b0
) (
   input  logic [W-1:0] d,
   output logic [W-1:0] mag,
   output logic         sign,
   output logic         sat
);

   localparam logic [W-1:0] MOST_NEG_W = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] MAX_POS_W  = {1'b0, {(W-1){1'b1}}};

   // Negate negative samples; clamp the one value with no positive twin when enabled.
   always_comb begin
      mag  = d;
      sign = d[W-1];
      sat  = 1'b0;
      if (d[W-1]) begin
         if (SAT && (d == MOST_NEG_W)) begin
            mag = MAX_POS_W;
            sat = 1'b1;
         end else begin
            mag = '0 - d;
         end
      end
   end

endmodule

// File: rtl/sign_mag_arbiter.sv
// Round-robin share of one registered sign/magnitude stage among N_CH channels.
module sign_mag_arbiter
   import filter_pkg::*;
#(
   parameter int unsigned N_CH = N_CH_DEF,
   parameter int unsigned W    = W_DEF,
   parameter bit          SAT  = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_CH-1:0]           req_valid,
   input  logic [N_CH*W-1:0]         req_data,
   output logic [N_CH-1:0]           req_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [W-1:0]              out_mag,
   output logic                      out_sign,
   output logic [$clog2(N_CH)-1:0]   out_ch,
   output logic                      sat_flag
);

   localparam int unsigned CW    = $clog2(N_CH);
   localparam logic [CW:0] NCH_W = (CW+1)'(N_CH);

   logic [CW-1:0]   rr_ptr;
   logic            load;
   logic [2*N_CH-1:0] dbl;
   logic [N_CH-1:0] rot;
   logic            found;
   logic [CW-1:0]   f_idx;
   logic [CW:0]     sum;
   logic [CW:0]     nsum;
   logic [CW-1:0]   gnt_idx;
   logic [CW-1:0]   ptr_nxt;
   logic            grant;
   logic [W-1:0]    sel_data;
   logic [W-1:0]    cv_mag;
   logic            cv_sign;
   logic            cv_sat;

   assign load = !out_valid || out_ready;

   // Rotate requests so rr_ptr sits at bit 0, find first, then un-rotate the index.
   always_comb begin
      dbl     = {req_valid, req_valid} >> rr_ptr;
      rot     = dbl[N_CH-1:0];
      found   = 1'b0;
      f_idx   = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            f_idx = CW'(i);
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, f_idx};
      if (sum >= NCH_W) sum = sum - NCH_W;
      gnt_idx = sum[CW-1:0];
      nsum = {1'b0, gnt_idx} + 1'b1;
      if (nsum == NCH_W) nsum = '0;
      ptr_nxt = nsum[CW-1:0];
      grant     = found && load && !rst;
      req_ready = '0;
      if (grant) req_ready[gnt_idx] = 1'b1;
      sel_data = req_data[gnt_idx*W +: W];
   end

   sign_mag_unit #(.W(W), .SAT(SAT)) u_conv (
      .d    (sel_data),
      .mag  (cv_mag),
      .sign (cv_sign),
      .sat  (cv_sat)
   );

   // Output register and round-robin pointer; a grant can coincide with a drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         out_valid <= 1'b0;
         out_mag   <= '0;
         out_sign  <= 1'b0;
         out_ch    <= '0;
         sat_flag  <= 1'b0;
      end else if (grant) begin
         rr_ptr    <= ptr_nxt;
         out_valid <= 1'b1;
         out_mag   <= cv_mag;
         out_sign  <= cv_sign;
         out_ch    <= gnt_idx;
         sat_flag  <= cv_sat;
      end else if (load) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sign_mag_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results, negedge monitors pop on transfer.
module tb_sign_mag_arbiter;

   typedef struct packed {
      logic [31:0] mag;
      logic        sign;
      logic [1:0]  ch;
      logic        sat;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic         out_ready;

   logic [3:0]   req_ready,  req_ready_s;
   logic         out_valid,  out_valid_s;
   logic [31:0]  out_mag,    out_mag_s;
   logic         out_sign,   out_sign_s;
   logic [1:0]   out_ch,     out_ch_s;
   logic         sat_flag,   sat_flag_s;

   res_t q0[$];
   res_t q1[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   sign_mag_arbiter #(.N_CH(4), .W(32), .SAT(1'b0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_mag(out_mag), .out_sign(out_sign), .out_ch(out_ch), .sat_flag(sat_flag)
   );

   sign_mag_arbiter #(.N_CH(4), .W(32), .SAT(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready_s), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_mag(out_mag_s), .out_sign(out_sign_s), .out_ch(out_ch_s), .sat_flag(sat_flag_s)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] mag, input logic sign, input logic [1:0] ch);
      res_t r;
      r = '{mag: mag, sign: sign, ch: ch, sat: 1'b0};
      q0.push_back(r);
      q1.push_back(r);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_data(input int ch, input logic [31:0] v);
      req_data[ch*32 +: 32] = v;
   endtask

   // Monitor for the wrapping instance.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         res_t e;
         if (q0.size() == 0) begin
            chk("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = q0.pop_front();
            chk("mag",  64'(out_mag),  64'(e.mag));
            chk("sign", 64'(out_sign), 64'(e.sign));
            chk("ch",   64'(out_ch),   64'(e.ch));
            chk("sat",  64'(sat_flag), 64'(e.sat));
         end
      end
   end

   // Monitor for the saturating instance.
   always @(negedge clk) begin
      if (!rst && out_valid_s && out_ready) begin
         res_t e;
         if (q1.size() == 0) begin
            chk("unexpected_out_sat", 64'(out_valid_s), 64'd0);
         end else begin
            e = q1.pop_front();
            chk("mag_sat",  64'(out_mag_s),  64'(e.mag));
            chk("sign_sat", 64'(out_sign_s), 64'(e.sign));
            chk("ch_sat",   64'(out_ch_s),   64'(e.ch));
            chk("sat_sat",  64'(sat_flag_s), 64'(e.sat));
         end
      end
   end

   initial begin
      res_t r;
      rst       = 1'b1;
      req_valid = 4'b1111;
      out_ready = 1'b1;
      req_data  = '0;
      for (int i = 0; i < 4; i++) set_data(i, 32'(i + 1));

      // Reset held two cycles with all channels requesting.
      for (int k = 0; k < 2; k++) begin
         cyc();
         settle();
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_out_valid", 64'(out_valid), 64'd0);
         chk("rst_out_mag",   64'(out_mag),   64'd0);
         chk("rst_out_sign",  64'(out_sign),  64'd0);
         chk("rst_out_ch",    64'(out_ch),    64'd0);
         chk("rst_sat_flag",  64'(sat_flag_s), 64'd0);
      end
      rst = 1'b0;
      settle();
      chk("first_grant", 64'(req_ready), 64'b0001);
      push(32'd1, 1'b0, 2'd0);
      cyc();
      req_valid = 4'b0000;
      settle();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_ch",    64'(out_ch),    64'd0);
      cyc();

      // Conversion values on ch2 alone, back to back.
      req_valid = 4'b0100;
      set_data(2, 32'h0000_0005);
      settle();
      chk("conv_grant0", 64'(req_ready), 64'b0100);
      push(32'd5, 1'b0, 2'd2);
      cyc();
      set_data(2, 32'hFFFF_FFFB);
      settle();
      chk("conv_valid1", 64'(out_valid), 64'd1);
      chk("conv_grant1", 64'(req_ready), 64'b0100);
      push(32'd5, 1'b1, 2'd2);
      cyc();
      set_data(2, 32'h0000_0000);
      settle();
      chk("conv_grant2", 64'(req_ready), 64'b0100);
      push(32'd0, 1'b0, 2'd2);
      cyc();
      set_data(2, 32'h8000_0000);
      settle();
      chk("neg_grant", 64'(req_ready), 64'b0100);
      r = '{mag: 32'h8000_0000, sign: 1'b1, ch: 2'd2, sat: 1'b0};
      q0.push_back(r);
      r = '{mag: 32'h7FFF_FFFF, sign: 1'b1, ch: 2'd2, sat: 1'b1};
      q1.push_back(r);
      cyc();
      req_valid = 4'b0000;
      settle();
      chk("neg_valid", 64'(out_valid), 64'd1);
      cyc();
      cyc();

      // Fairness: all channels valid for 12 cycles from a fresh pointer.
      set_data(0, 32'hFFFF_FFFF);
      set_data(1, 32'h0000_0064);
      set_data(2, 32'hFFFF_FF9C);
      set_data(3, 32'h7FFF_FFFF);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         settle();
         chk("fair_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
         case (i % 4)
            0: push(32'd1,          1'b1, 2'd0);
            1: push(32'h64,         1'b0, 2'd1);
            2: push(32'h64,         1'b1, 2'd2);
            default: push(32'h7FFF_FFFF, 1'b0, 2'd3);
         endcase
         cyc();
      end

      // Backpressure with the ch3 result pending.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_valid",     64'(out_valid), 64'd1);
         chk("bp_mag",       64'(out_mag),   64'h7FFF_FFFF);
         chk("bp_ch",        64'(out_ch),    64'd3);
         cyc();
      end
      out_ready = 1'b1;
      settle();
      chk("bp_release_grant", 64'(req_ready), 64'b0001);
      cyc();

      // Mid-operation reset: ch0 result pending, pointer at ch1; it is dropped.
      out_ready = 1'b0;
      rst = 1'b1;
      settle();
      chk("mid_pending", 64'(out_valid), 64'd1);
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      cyc();
      settle();
      chk("mid_valid_cleared", 64'(out_valid), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      settle();
      chk("mid_ptr_reset_grant", 64'(req_ready), 64'b0001);
      push(32'd1, 1'b1, 2'd0);
      cyc();
      req_valid = 4'b0000;
      cyc();
      cyc();

      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sign_mag_arbiter.md
# sign_mag_arbiter

Round-robin scheduler that shares a single registered sign/magnitude conversion stage among `N_CH` filter channels. Each channel offers a signed two's-complement sample with a valid/ready handshake. The block grants one channel per cycle, converts the sample into magnitude plus sign, and presents the result with its channel tag to the downstream PWM/motor-command logic. It sits between the per-channel filter outputs and the motor driver interface.

## Interface
- `N_CH`, default 4, number of requesting channels (2..8).
- `W`, default 32, sample width in bits.
- `SAT`, default 0. When 1, the most-negative input produces magnitude `2^(W-1)-1`. When 0, it produces the two's-complement wrap `2^(W-1)`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_CH: per-channel sample-valid signal.
- `req_data` input N_CH*W: channel i occupies bits `[i*W +: W]`, signed.
- `req_ready` output N_CH: one-hot grant; a transfer occurs when `req_valid[i] && req_ready[i]`.
- `out_valid` output 1: result register holds a valid result.
- `out_ready` input 1: downstream accepts the result.
- `out_mag` output W: unsigned magnitude.
- `out_sign` output 1: 1 if the input was negative.
- `out_ch` output clog2(N_CH): index of the source channel.
- `sat_flag` output 1: high with a result if SAT clamped that sample.

## Operation
- **Pointer.** `rr_ptr` holds the highest-priority channel. Reset value is 0.
- **Load condition.** `load = !out_valid || out_ready`.
- **Grant.** When `load` is true, grant the first channel with `req_valid` set, searching from `rr_ptr` upward and wrapping modulo N_CH.
  - `req_ready` is one-hot on the granted channel.
  - All `req_ready` bits are 0 if `load` is false or no channel is requesting.
  - `req_ready` never depends on `req_valid` of the same channel beyond this selection.
- **After a grant to channel g.** `rr_ptr <= (g+1) mod N_CH`. The pointer is unchanged when nothing is granted.
- **Conversion** (registered, on grant):
  - If `d[W-1] == 0`: `out_mag = d`, `out_sign = 0`.
  - Otherwise: `out_mag = 0 - d`, truncated to W bits, and `out_sign = 1`.
  - Exception: if `d == 1<<(W-1)` and `SAT == 1`, then `out_mag = (1<<(W-1))-1` and `sat_flag = 1`.
  - Zero gives magnitude 0 and sign 0.
- **Output register update.**
  - On grant: `out_valid <= 1` and data, sign, ch and sat are loaded.
  - When `load` is true with no grant: `out_valid <= 0`.
  - Otherwise the register holds. Data must be stable while `out_valid && !out_ready`.
- **Reset.** All outputs and state go to 0: `out_valid`, `out_mag`, `out_sign`, `out_ch`, `sat_flag` and `rr_ptr`. `req_ready` is 0 during reset. Reset asserted mid-transfer drops the pending result, with no replay.

## Timing
- Latency is 1 cycle. A sample accepted at edge t appears with `out_valid = 1` after edge t, ready to transfer at edge t+1.
- Throughput is one result per cycle while `out_ready = 1`. Back-to-back grants are allowed with no bubble.
- Simultaneous output drain and new grant in the same cycle are both honoured.
- Under backpressure, `req_ready` is all zero the same cycle (combinational from `out_valid`/`out_ready`).
- Fairness: with all channels continuously valid and `out_ready = 1`, grants rotate 0,1,…,N_CH-1. No channel waits more than N_CH-1 grants.

## Structure
- Shared package `filter_pkg`:
  - `N_CH_DEF` and `W_DEF`.
  - Typedef `ch_id_t` (clog2(N_CH) bits).
  - Constant `MOST_NEG = 1<<(W-1)`.
- Sub-module `sign_mag_unit`: combinational W-bit sign/magnitude conversion with SAT handling. It is instantiated once; the output register lives in `sign_mag_arbiter`.
- The round-robin priority pick is kept inline, as a rotate, find-first, un-rotate sequence.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with all `req_valid = 1`. All outputs stay 0 and `req_ready = 0`. After release, the first grant goes to ch0.
- **Conversion values.** Single channel ch2 sends `0x00000005`, `0xFFFFFFFB`, `0x00000000`.
  - Required results: `(5,0,ch2)`, `(5,1,ch2)`, `(0,0,ch2)`, each 1 cycle after its handshake.
- **Most-negative input.** Send `0x80000000`.
  - With SAT=0: `out_mag = 0x80000000`, `out_sign = 1`, `sat_flag = 0`.
  - With SAT=1: `out_mag = 0x7FFFFFFF`, `sat_flag = 1`.
- **Fairness.** All 4 channels continuously valid, `out_ready = 1`, 12 cycles. `out_ch` sequence is 0,1,2,3 repeated exactly 3 times, with no gaps.
- **Backpressure.** Hold `out_ready = 0` for 5 cycles while results are pending.
  - `req_ready` stays all-zero and the output is stable.
  - On release, the held result transfers and the next grant happens in the same cycle.
- **Mid-operation reset.** Pulse `rst` while `out_valid = 1` and ch1 is pointed to. Next cycle: `out_valid = 0` and `rr_ptr = 0`, with ch0 granted first.
